// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard inputs and stall/flush/forward outputs.
// Optional performance counters appear only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       loadE, regwrM, regwrW, br_takenE, mdv_startE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, mdv_busy;
  logic [1:0] fwdAE, fwdBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_stalls, perf_flushes, perf_mdv_stalls;
`endif

  // pipeline side: drives hazard inputs, consumes controls
  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output loadE, regwrM, regwrW, br_takenE, mdv_startE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM, mdv_busy,
    input  fwdAE, fwdBE
`ifdef HAZARD_PERF_EN
    , input perf_lu_stalls, perf_flushes, perf_mdv_stalls
`endif
  );

  // controller side
  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  loadE, regwrM, regwrW, br_takenE, mdv_startE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM, mdv_busy,
    output fwdAE, fwdBE
`ifdef HAZARD_PERF_EN
    , output perf_lu_stalls, perf_flushes, perf_mdv_stalls
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage RV32I pipeline: load-use stall,
// branch flush, EX operand forwarding and a RUN/MDV mul/div hold machine.
// Optional macro HAZARD_PERF_EN adds saturating 32-bit event counters.
module hazard_ctrl #(
  parameter int MDV_LAT = 4,
  parameter int CNT_W   = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN = 1'b0, MDV = 1'b1} state_t;

  // The entry cycle is the first of the MDV_LAT-1 stalled cycles, so the
  // register tracks the MDV-state cycles that remain after it.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDV_LAT - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rel;    // first RUN cycle after release: op's final EX cycle
  logic             in_run, br, start, lu, busy;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hz.regwrM && hz.rdM != 5'd0 && hz.rdM == rs)      fwd_sel = 2'b10;
    else if (hz.regwrW && hz.rdW != 5'd0 && hz.rdW == rs) fwd_sel = 2'b01;
    else                                                   fwd_sel = 2'b00;
  endfunction

  assign in_run = (state == RUN);
  assign br     = in_run & hz.br_takenE;
  assign start  = in_run & ~rel & hz.mdv_startE & ~hz.br_takenE;
  assign lu     = in_run & hz.loadE & (hz.rdE != 5'd0) &
                  ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));
  assign busy   = ~in_run | start;

  // Control outputs: zero-latency from state/inputs, all quiet while rst held
  always_comb begin
    hz.StallF   = 1'b0;
    hz.StallD   = 1'b0;
    hz.StallE   = 1'b0;
    hz.FlushD   = 1'b0;
    hz.FlushE   = 1'b0;
    hz.FlushM   = 1'b0;
    hz.mdv_busy = 1'b0;
    hz.fwdAE    = 2'b00;
    hz.fwdBE    = 2'b00;
    if (!rst) begin
      hz.StallF   = busy | (lu & ~br);
      hz.StallD   = busy | (lu & ~br);
      hz.StallE   = busy;
      hz.FlushD   = br;
      hz.FlushE   = br | lu;
      hz.FlushM   = busy;
      hz.mdv_busy = busy;
      hz.fwdAE    = fwd_sel(hz.rs1E);
      hz.fwdBE    = fwd_sel(hz.rs2E);
    end
  end

  // RUN/MDV sequencing with countdown and post-release re-trigger guard
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      rel   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          rel <= 1'b0;
          if (start) begin
            if (MDV_LAT > 2) begin
              state <= MDV;
              cnt   <= CNT_LOAD;
            end else begin
              rel <= 1'b1;
            end
          end
        end
        MDV: begin
          if (cnt == CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
          rel   <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] pc_lu, pc_fl, pc_mdv;
  assign hz.perf_lu_stalls  = pc_lu;
  assign hz.perf_flushes    = pc_fl;
  assign hz.perf_mdv_stalls = pc_mdv;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_lu  <= '0;
      pc_fl  <= '0;
      pc_mdv <= '0;
    end else begin
      if (lu && !br && pc_lu != 32'hFFFF_FFFF)   pc_lu  <= pc_lu + 32'd1;
      if (br && pc_fl != 32'hFFFF_FFFF)          pc_fl  <= pc_fl + 32'd1;
      if (busy && pc_mdv != 32'hFFFF_FFFF)       pc_mdv <= pc_mdv + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus random bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int MDV_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // reference model state: MDV cycles still to go, and final-EX-cycle guard
  int   rem = 0;
  bit   ign = 1'b0;
  logic [10:0] last;
  longint m_lu = 0, m_fl = 0, m_mdv = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hif ();
  hazard_ctrl #(.MDV_LAT(MDV_LAT), .CNT_W(4)) dut (.clk(clk), .rst(rst), .hz(hif));

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (hif.regwrM && hif.rdM != 0 && hif.rdM == rs) return 2'b10;
    if (hif.regwrW && hif.rdW != 0 && hif.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    hif.rs1D = 0; hif.rs2D = 0; hif.rs1E = 0; hif.rs2E = 0;
    hif.rdE = 0; hif.rdM = 0; hif.rdW = 0;
    hif.loadE = 0; hif.regwrM = 0; hif.regwrW = 0;
    hif.br_takenE = 0; hif.mdv_startE = 0;
  endtask

  task automatic rnd();
    hif.rs1D = 5'($urandom_range(0, 3)); hif.rs2D = 5'($urandom_range(0, 3));
    hif.rs1E = 5'($urandom_range(0, 3)); hif.rs2E = 5'($urandom_range(0, 3));
    hif.rdE  = 5'($urandom_range(0, 3)); hif.rdM  = 5'($urandom_range(0, 3));
    hif.rdW  = 5'($urandom_range(0, 3));
    hif.loadE      = ($urandom_range(0, 2) == 0);
    hif.regwrM     = 1'($urandom);
    hif.regwrW     = 1'($urandom);
    hif.br_takenE  = ($urandom_range(0, 7) == 0);
    hif.mdv_startE = ($urandom_range(0, 5) == 0);
  endtask

  // one clock: check outputs at negedge against the model, then advance
  task automatic cyc();
    logic [10:0] exp, got;
    bit run, start, busy, lu, brk, sf;
    @(negedge clk);
    run   = (rem == 0);
    start = run && hif.mdv_startE && !hif.br_takenE && !ign;
    busy  = !run || start;
    lu    = run && hif.loadE && hif.rdE != 0 &&
            (hif.rdE == hif.rs1D || hif.rdE == hif.rs2D);
    brk   = run && hif.br_takenE;
    sf    = busy || (lu && !brk);
    if (rst) exp = '0;
    else     exp = {sf, sf, busy, brk, brk || lu, busy, busy,
                    fwd_ref(hif.rs1E), fwd_ref(hif.rs2E)};
    got = {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE,
           hif.FlushM, hif.mdv_busy, hif.fwdAE, hif.fwdBE};
    last = got;
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL outs t=%0t got=%b exp=%b", $time, got, exp);
    end
`ifdef HAZARD_PERF_EN
    tests++;
    assert ({hif.perf_lu_stalls, hif.perf_flushes, hif.perf_mdv_stalls} ===
            {m_lu[31:0], m_fl[31:0], m_mdv[31:0]}) else begin
      fails++;
      $error("FAIL perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", hif.perf_lu_stalls,
             hif.perf_flushes, hif.perf_mdv_stalls, m_lu, m_fl, m_mdv);
    end
`endif
    if (rst) begin
      rem = 0; ign = 0; m_lu = 0; m_fl = 0; m_mdv = 0;
    end else begin
      if (lu && !brk && m_lu < 64'hFFFF_FFFF) m_lu++;
      if (brk && m_fl < 64'hFFFF_FFFF)        m_fl++;
      if (busy && m_mdv < 64'hFFFF_FFFF)      m_mdv++;
      if (!run) begin
        rem--; ign = (rem == 0);
      end else if (start) begin
        rem = MDV_LAT - 2; ign = (rem == 0);
      end else begin
        ign = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int stalls;
    idle();
    rst = 1;
    // reset with random inputs
    rnd(); cyc(); chk("rst_q0", last[10:7], 4'h0);
    rnd(); cyc(); chk("rst_q1", {last[6:4], 1'b0}, 4'h0);
    rst = 0; idle(); cyc();

    // load-use on rs1D
    hif.loadE = 1; hif.rdE = 5; hif.rs1D = 5; cyc();
    chk("lu_stall", {last[10:9], last[6], 1'b0}, 4'b1110);
    idle(); cyc();
    // rdE = x0: no stall
    hif.loadE = 1; hif.rdE = 0; hif.rs1D = 0; cyc();
    chk("lu_x0", {last[10:9], last[6], 1'b0}, 4'b0000);
    // load-use with branch taken the same cycle
    idle(); hif.loadE = 1; hif.rdE = 5; hif.rs2D = 5; hif.br_takenE = 1; cyc();
    chk("br_prio", {last[10:9], last[7:6]}, 4'b0011);

    // mul/div held 4 cycles, branch pulse mid-busy ignored
    idle(); stalls = 0;
    for (int i = 0; i < 4; i++) begin
      hif.mdv_startE = 1;
      hif.br_takenE  = (i == 1);
      cyc();
      stalls += int'(last[8]);
    end
    chk("mdv_stalls", 4'(stalls), 4'd3);
    chk("mdv_rel", {3'b000, last[4]}, 4'd0);
    idle(); cyc();

    // forwarding priority
    hif.regwrM = 1; hif.rdM = 7; hif.regwrW = 1; hif.rdW = 7;
    hif.rs1E = 7; hif.rs2E = 3; cyc();
    chk("fwd_mem", last[3:0], 4'b1000);
    hif.regwrM = 0; cyc();
    chk("fwd_wb", last[3:0], 4'b0100);

    // reset on the second MDV cycle
    idle(); hif.mdv_startE = 1; cyc();
    hif.mdv_startE = 0; cyc();
    rst = 1; cyc();
    rst = 0; cyc();
    chk("rst_mdv", {2'b00, last[8], last[4]}, 4'd0);
`ifdef HAZARD_PERF_EN
    chk("rst_perf", 4'(hif.perf_mdv_stalls), 4'd0);
`endif

    // random phase
    for (int i = 0; i < 500; i++) begin
      rnd();
      rst = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 0; idle(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
